// File: rtl/pp_data_buf.sv
// pp_data_buf: ping-pong row buffer with two banks of ROW_CNT x DATA_W.
// A producer fills and commits one bank while a consumer reads the other.
// Bank ownership moves by commit/release; reads are registered with a valid strobe.
// Optional feature macro: PP_DATA_BUF_ERR_EN adds a sticky protocol error output (err).
module pp_data_buf #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ROW_CNT = 4,
  parameter int unsigned ADDR_W  = $clog2(ROW_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_ready
`ifdef PP_DATA_BUF_ERR_EN
  ,
  output logic              err
`endif
);

  localparam logic [ADDR_W:0] ROW_LIM = (ADDR_W+1)'(ROW_CNT);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] mem_q [2][ROW_CNT];
  logic [DATA_W-1:0] mem_d [2][ROW_CNT];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic wr_acc, commit_acc, rd_acc, rel_acc;
  logic wr_in_range, rd_in_range;

  // Handshake readiness depends only on registered bank state.
  always_comb begin
    wr_ready    = ~full_q[wr_bank_q];
    rd_ready    = full_q[rd_bank_q];
    wr_acc      = wr_en & wr_ready;
    commit_acc  = wr_commit & wr_ready;
    rd_acc      = rd_en & rd_ready;
    rel_acc     = rd_release & rd_ready;
    wr_in_range = ({1'b0, wr_addr} < ROW_LIM);
    rd_in_range = ({1'b0, rd_addr} < ROW_LIM);
  end

  // Next state: bank flags/pointers, memory write, registered read.
  // Commit and release accepted together always touch different banks.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    mem_d      = mem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (wr_acc && wr_in_range) begin
      mem_d[wr_bank_q][wr_addr] = wr_data;
    end
    if (commit_acc) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_acc) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_in_range ? mem_q[rd_bank_q][rd_addr] : '0;
    end
    if (rel_acc) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State registers with asynchronous reset; memory clears to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROW_CNT); r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef PP_DATA_BUF_ERR_EN
  logic err_q, err_d;

  // Sticky flag for any ignored request or out-of-range accepted access.
  always_comb begin
    err_d = err_q
          | (wr_en      & ~wr_ready)
          | (wr_commit  & ~wr_ready)
          | (rd_en      & ~rd_ready)
          | (rd_release & ~rd_ready)
          | (wr_acc     & ~wr_in_range)
          | (rd_acc     & ~rd_in_range);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
